// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
// Entries are allocated in order at tail, completed out of order by the
// writeback ports, and retired in order from head one per cycle. Stores
// handshake with memory at head. Branch mispredicts and jalr flush the
// whole buffer and redirect fetch.
module rob_param #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int XLEN     = 32,
  parameter int WB_PORTS = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       rdy,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [1:0]                 alloc_kind,
  input  logic [4:0]                 alloc_dest,
  input  logic [XLEN-1:0]            alloc_pc,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]  wb_tag,
  input  logic [WB_PORTS*XLEN-1:0]   wb_value,
  input  logic [WB_PORTS*XLEN-1:0]   wb_aux,
  input  logic [WB_PORTS-1:0]        wb_redirect,
  input  logic [RD_PORTS*TAG_W-1:0]  rd_tag,
  output logic [RD_PORTS-1:0]        rd_done,
  output logic [RD_PORTS*XLEN-1:0]   rd_value,
  output logic                       commit_valid,
  output logic [4:0]                 commit_dest,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [XLEN-1:0]            commit_value,
  output logic                       store_valid,
  output logic [XLEN-1:0]            store_addr,
  output logic [XLEN-1:0]            store_data,
  input  logic                       store_ready,
  output logic                       flush_valid,
  output logic [XLEN-1:0]            flush_pc,
  output logic [TAG_W:0]             count
);

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_JALR   = 2'd3
  } kind_e;

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] redir_q;
  kind_e            kind_q  [DEPTH];
  logic [4:0]       dest_q  [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];
  logic [XLEN-1:0]  aux_q   [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  kind_e            head_kind;
  logic             head_ready;
  logic             retire_now;
  logic             flush_now;
  logic             alloc_fire;
  logic [TAG_W-1:0] wb_idx [WB_PORTS];
  logic [WB_PORTS-1:0] wb_hit;
  logic [TAG_W-1:0] rd_idx [RD_PORTS];

  assign head_kind   = kind_q[head];
  assign head_ready  = occ[head] && done[head];
  assign retire_now  = rdy && head_ready && ((head_kind != KIND_STORE) || store_ready);
  assign flush_now   = retire_now &&
                       (((head_kind == KIND_BRANCH) && redir_q[head]) || (head_kind == KIND_JALR));
  assign alloc_ready = (count < FULL) && !flush_valid;
  assign alloc_fire  = rdy && alloc_valid && alloc_ready;
  assign alloc_tag   = tail;

  assign store_valid = head_ready && (head_kind == KIND_STORE);
  assign store_addr  = store_valid ? value_q[head] : '0;
  assign store_data  = store_valid ? aux_q[head]   : '0;

  // Decode which writeback ports hit an occupied entry that is still pending.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_idx[p] = wb_tag[p*TAG_W +: TAG_W];
      wb_hit[p] = wb_valid[p] && occ[wb_idx[p]] && !done[wb_idx[p]];
    end
  end

  // Source lookups read current entry state; writebacks show up one cycle later.
  always_comb begin
    rd_done  = '0;
    rd_value = '0;
    for (int q = 0; q < RD_PORTS; q++) begin
      rd_idx[q]                  = rd_tag[q*TAG_W +: TAG_W];
      rd_done[q]                 = occ[rd_idx[q]] && done[rd_idx[q]];
      rd_value[q*XLEN +: XLEN]   = value_q[rd_idx[q]];
    end
  end

  // Entry array and pointers: allocate at tail, complete on writeback, retire at head, flush all.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      occ     <= '0;
      done    <= '0;
      redir_q <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        kind_q[i]  <= KIND_ALU;
        dest_q[i]  <= '0;
        pc_q[i]    <= '0;
        value_q[i] <= '0;
        aux_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (flush_now) begin
        occ   <= '0;
        done  <= '0;
        head  <= tail;
        count <= '0;
      end else begin
        // Highest port first so the lowest port index lands last and wins a tag conflict.
        for (int p = WB_PORTS-1; p >= 0; p--) begin
          if (wb_hit[p]) begin
            done[wb_idx[p]]    <= 1'b1;
            value_q[wb_idx[p]] <= wb_value[p*XLEN +: XLEN];
            aux_q[wb_idx[p]]   <= wb_aux[p*XLEN +: XLEN];
            redir_q[wb_idx[p]] <= wb_redirect[p];
          end
        end
        if (alloc_fire) begin
          occ[tail]     <= 1'b1;
          done[tail]    <= 1'b0;
          redir_q[tail] <= 1'b0;
          kind_q[tail]  <= kind_e'(alloc_kind);
          dest_q[tail]  <= alloc_dest;
          pc_q[tail]    <= alloc_pc;
          tail          <= tail + TAG_W'(1);
        end
        if (retire_now) begin
          occ[head]  <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + TAG_W'(1);
        end
        count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_now);
      end
    end
  end

  // Registered retire and redirect pulses; payloads hold between pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_tag   <= '0;
      commit_value <= '0;
      flush_valid  <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= 1'b0;
      flush_valid  <= 1'b0;
      if (retire_now) begin
        if (head_kind != KIND_STORE) begin
          commit_valid <= 1'b1;
          commit_tag   <= head;
          commit_dest  <= (head_kind == KIND_BRANCH) ? 5'd0 : dest_q[head];
          commit_value <= (head_kind == KIND_JALR) ? (pc_q[head] + XLEN'(4)) : value_q[head];
        end
        if (flush_now) begin
          flush_valid <= 1'b1;
          flush_pc    <= {aux_q[head][XLEN-1:1], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed self-checking bench for rob_param.
module tb_rob_param;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int WBP   = 2;
  localparam int RDP   = 2;

  logic                   clk;
  logic                   clr;
  logic                   rdy;
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [1:0]             alloc_kind;
  logic [4:0]             alloc_dest;
  logic [XLEN-1:0]        alloc_pc;
  logic [TAG_W-1:0]       alloc_tag;
  logic [WBP-1:0]         wb_valid;
  logic [WBP*TAG_W-1:0]   wb_tag;
  logic [WBP*XLEN-1:0]    wb_value;
  logic [WBP*XLEN-1:0]    wb_aux;
  logic [WBP-1:0]         wb_redirect;
  logic [RDP*TAG_W-1:0]   rd_tag;
  logic [RDP-1:0]         rd_done;
  logic [RDP*XLEN-1:0]    rd_value;
  logic                   commit_valid;
  logic [4:0]             commit_dest;
  logic [TAG_W-1:0]       commit_tag;
  logic [XLEN-1:0]        commit_value;
  logic                   store_valid;
  logic [XLEN-1:0]        store_addr;
  logic [XLEN-1:0]        store_data;
  logic                   store_ready;
  logic                   flush_valid;
  logic [XLEN-1:0]        flush_pc;
  logic [TAG_W:0]         count;

  int checks = 0;
  int errors = 0;
  logic [TAG_W-1:0] jtag;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .WB_PORTS(WBP), .RD_PORTS(RDP)) dut (
    .clk(clk), .clr(clr), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
    .alloc_dest(alloc_dest), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_aux(wb_aux),
    .wb_redirect(wb_redirect),
    .rd_tag(rd_tag), .rd_done(rd_done), .rd_value(rd_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_tag(commit_tag),
    .commit_value(commit_value),
    .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
    .store_ready(store_ready),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge from a negedge to the next negedge, then drop one-shot strobes.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
    alloc_valid = 1'b0;
    wb_valid    = '0;
    wb_redirect = '0;
  endtask

  task automatic allocOne(input logic [1:0] kind, input logic [4:0] dest, input logic [XLEN-1:0] pc);
    alloc_valid = 1'b1;
    alloc_kind  = kind;
    alloc_dest  = dest;
    alloc_pc    = pc;
    applyStimulus();
  endtask

  task automatic setWb(input int p, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v,
                       input logic [XLEN-1:0] a, input logic r);
    wb_valid[p]                = 1'b1;
    wb_tag[p*TAG_W +: TAG_W]   = t;
    wb_value[p*XLEN +: XLEN]   = v;
    wb_aux[p*XLEN +: XLEN]     = a;
    wb_redirect[p]             = r;
  endtask

  task automatic resetDut();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_kind = '0; alloc_dest = '0; alloc_pc = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; wb_aux = '0; wb_redirect = '0;
    rd_tag = '0; store_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_commit", 64'(commit_valid), 64'd0);
    checkOutput("rst_store", 64'(store_valid), 64'd0);
    checkOutput("rst_flush", 64'(flush_valid), 64'd0);
    checkOutput("rst_ready", 64'(alloc_ready), 64'd1);
    checkOutput("rst_tag", 64'(alloc_tag), 64'd0);
    clr = 1'b0;

    // Fill all entries, then retire the head.
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("fill_tag%0d", i), 64'(alloc_tag), 64'(i));
      allocOne(2'd0, 5'(i + 1), XLEN'(32'h100 + 4 * i));
    end
    checkOutput("fill_count", 64'(count), 64'd16);
    checkOutput("fill_ready", 64'(alloc_ready), 64'd0);
    checkOutput("fill_wrap", 64'(alloc_tag), 64'd0);
    setWb(0, 4'd0, 32'h100, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("fill_still_full", 64'(alloc_ready), 64'd0);
    applyStimulus();
    checkOutput("fill_commit", 64'(commit_valid), 64'd1);
    checkOutput("fill_cval", 64'(commit_value), 64'h100);
    checkOutput("fill_count15", 64'(count), 64'd15);
    checkOutput("fill_ready1", 64'(alloc_ready), 64'd1);
    resetDut();

    // Out-of-order writebacks retire strictly in order.
    allocOne(2'd0, 5'd1, 32'h10);
    allocOne(2'd0, 5'd2, 32'h14);
    allocOne(2'd0, 5'd3, 32'h18);
    setWb(0, 4'd2, 32'h22, 32'h0, 1'b0);
    applyStimulus();
    rd_tag = {4'd1, 4'd2};
    #1;
    checkOutput("ooo_rd0_done", 64'(rd_done[0]), 64'd1);
    checkOutput("ooo_rd0_val", 64'(rd_value[XLEN-1:0]), 64'h22);
    checkOutput("ooo_rd1_done", 64'(rd_done[1]), 64'd0);
    setWb(1, 4'd1, 32'h11, 32'h0, 1'b0);
    applyStimulus();
    setWb(0, 4'd0, 32'h10, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("ooo_nocommit", 64'(commit_valid), 64'd0);
    applyStimulus();
    checkOutput("ooo_c0_v", 64'(commit_valid), 64'd1);
    checkOutput("ooo_c0_tag", 64'(commit_tag), 64'd0);
    checkOutput("ooo_c0_val", 64'(commit_value), 64'h10);
    checkOutput("ooo_c0_dest", 64'(commit_dest), 64'd1);
    applyStimulus();
    checkOutput("ooo_c1_v", 64'(commit_valid), 64'd1);
    checkOutput("ooo_c1_tag", 64'(commit_tag), 64'd1);
    checkOutput("ooo_c1_val", 64'(commit_value), 64'h11);
    applyStimulus();
    checkOutput("ooo_c2_v", 64'(commit_valid), 64'd1);
    checkOutput("ooo_c2_tag", 64'(commit_tag), 64'd2);
    checkOutput("ooo_c2_val", 64'(commit_value), 64'h22);
    applyStimulus();
    checkOutput("ooo_idle", 64'(commit_valid), 64'd0);
    checkOutput("ooo_count", 64'(count), 64'd0);
    resetDut();

    // Two ports write the same tag in one cycle: port 0 wins.
    for (int i = 0; i < 4; i++) allocOne(2'd0, 5'(i + 4), XLEN'(32'h200 + 4 * i));
    setWb(0, 4'd3, 32'hAA, 32'h0, 1'b0);
    setWb(1, 4'd3, 32'hBB, 32'h0, 1'b0);
    applyStimulus();
    rd_tag = {4'd0, 4'd3};
    #1;
    checkOutput("dual_rd_val", 64'(rd_value[XLEN-1:0]), 64'hAA);
    setWb(0, 4'd0, 32'h1, 32'h0, 1'b0);
    setWb(1, 4'd1, 32'h2, 32'h0, 1'b0);
    applyStimulus();
    setWb(0, 4'd2, 32'h3, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("dual_c0_tag", 64'(commit_tag), 64'd0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("dual_c3_v", 64'(commit_valid), 64'd1);
    checkOutput("dual_c3_tag", 64'(commit_tag), 64'd3);
    checkOutput("dual_c3_val", 64'(commit_value), 64'hAA);
    resetDut();

    // Mispredicted branch at head flushes younger entries; then a jalr.
    allocOne(2'd1, 5'd9, 32'h800);
    allocOne(2'd0, 5'd10, 32'h804);
    allocOne(2'd0, 5'd11, 32'h808);
    setWb(0, 4'd0, 32'h0, 32'h1001, 1'b1);
    setWb(1, 4'd1, 32'h77, 32'h0, 1'b0);
    applyStimulus();
    setWb(0, 4'd2, 32'h88, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("mp_flush_v", 64'(flush_valid), 64'd1);
    checkOutput("mp_flush_pc", 64'(flush_pc), 64'h1000);
    checkOutput("mp_count", 64'(count), 64'd0);
    checkOutput("mp_ready_blk", 64'(alloc_ready), 64'd0);
    applyStimulus();
    checkOutput("mp_flush_drop", 64'(flush_valid), 64'd0);
    checkOutput("mp_ready", 64'(alloc_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("mp_nocommit%0d", i), 64'(commit_valid), 64'd0);
      applyStimulus();
    end
    jtag = alloc_tag;
    allocOne(2'd3, 5'd5, 32'h400);
    setWb(0, jtag, 32'h0, 32'h2003, 1'b0);
    applyStimulus();
    applyStimulus();
    checkOutput("jalr_cv", 64'(commit_valid), 64'd1);
    checkOutput("jalr_dest", 64'(commit_dest), 64'd5);
    checkOutput("jalr_val", 64'(commit_value), 64'h404);
    checkOutput("jalr_flush", 64'(flush_valid), 64'd1);
    checkOutput("jalr_pc", 64'(flush_pc), 64'h2002);
    resetDut();

    // Store at head stalls until memory accepts it.
    allocOne(2'd2, 5'd0, 32'h900);
    allocOne(2'd0, 5'd7, 32'h904);
    setWb(0, 4'd0, 32'h20, 32'h5, 1'b0);
    setWb(1, 4'd1, 32'h99, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("st_valid", 64'(store_valid), 64'd1);
    checkOutput("st_addr", 64'(store_addr), 64'h20);
    checkOutput("st_data", 64'(store_data), 64'h5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("st_hold%0d", i), 64'(store_valid), 64'd1);
      checkOutput($sformatf("st_cnt%0d", i), 64'(count), 64'd2);
      checkOutput($sformatf("st_nocv%0d", i), 64'(commit_valid), 64'd0);
    end
    rdy = 1'b0;
    store_ready = 1'b1;
    applyStimulus();
    checkOutput("st_frozen_v", 64'(store_valid), 64'd1);
    checkOutput("st_frozen_cnt", 64'(count), 64'd2);
    rdy = 1'b1;
    applyStimulus();
    store_ready = 1'b0;
    checkOutput("st_retired", 64'(store_valid), 64'd0);
    checkOutput("st_no_commit", 64'(commit_valid), 64'd0);
    checkOutput("st_cnt1", 64'(count), 64'd1);
    applyStimulus();
    checkOutput("st_next_cv", 64'(commit_valid), 64'd1);
    checkOutput("st_next_val", 64'(commit_value), 64'h99);
    checkOutput("st_next_dest", 64'(commit_dest), 64'd7);
    resetDut();

    // Asynchronous clear between edges while a commit pulse and a store are visible.
    allocOne(2'd0, 5'd3, 32'hA00);
    allocOne(2'd2, 5'd0, 32'hA04);
    setWb(0, 4'd0, 32'h55, 32'h0, 1'b0);
    setWb(1, 4'd1, 32'h40, 32'h9, 1'b0);
    applyStimulus();
    applyStimulus();
    checkOutput("ac_pre_cv", 64'(commit_valid), 64'd1);
    checkOutput("ac_pre_sv", 64'(store_valid), 64'd1);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("ac_cv", 64'(commit_valid), 64'd0);
    checkOutput("ac_cval", 64'(commit_value), 64'd0);
    checkOutput("ac_sv", 64'(store_valid), 64'd0);
    checkOutput("ac_saddr", 64'(store_addr), 64'd0);
    checkOutput("ac_count", 64'(count), 64'd0);
    checkOutput("ac_tag", 64'(alloc_tag), 64'd0);
    @(negedge clk);
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer, successor to the fixed 16-entry ROB. It sits between the decoder/issue stage and the register file, store path and fetch redirect. Depth, data width, writeback port count and source-lookup port count are configurable. It uses all DEPTH entries (no sacrificed slot), accepts multiple writebacks per cycle, performs in-order single retirement, handshakes stores and issues precise flush on branch mispredict.

## Interface
- DEPTH, 16: entries; power of two, ≥4
- TAG_W, $clog2(DEPTH): tag width
- XLEN, 32: data width
- WB_PORTS, 2: writeback ports
- RD_PORTS, 2: source-lookup ports
- clk  in  1  clock
- clr  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  decoder offers instruction
- alloc_ready  out  1  combinational: count<DEPTH && !flush_valid
- alloc_kind  in  2  0 ALU/load, 1 branch, 2 store, 3 jalr
- alloc_dest  in  5  destination register (0 = none)
- alloc_pc  in  XLEN  instruction PC
- alloc_tag  out  TAG_W  combinational = tail; tag of offered instruction
- wb_valid  in  WB_PORTS  per-port writeback strobe
- wb_tag  in  WB_PORTS*TAG_W  target entry per port
- wb_value  in  WB_PORTS*XLEN  result (store: address)
- wb_aux  in  WB_PORTS*XLEN  store data / branch-or-jalr target
- wb_redirect  in  WB_PORTS  branch mispredicted (ignored for other kinds)
- rd_tag  in  RD_PORTS*TAG_W  source lookup tags
- rd_done  out  RD_PORTS  combinational: entry occupied and done
- rd_value  out  RD_PORTS*XLEN  combinational value of looked-up entry
- commit_valid  out  1  registered one-cycle retire pulse to regfile
- commit_dest / commit_tag / commit_value  out  5 / TAG_W / XLEN  retire payload
- store_valid  out  1  head is a done store
- store_addr / store_data  out  XLEN / XLEN  head store payload
- store_ready  in  1  memory accepts store
- flush_valid  out  1  registered one-cycle redirect pulse
- flush_pc  out  XLEN  redirect target
- count  out  TAG_W+1  occupied entries

## Operation
- State: per-entry occupied, done, kind, dest, pc, value, aux, redirect; head, tail (TAG_W, wrap naturally), count.
- Reset (clr): head=tail=count=0, all occupied/done=0, commit_valid=store_valid=flush_valid=0, all payload outputs 0.
- Allocate on alloc_valid&&alloc_ready&&rdy: write entry at tail, occupied=1, done=0, tail+1, count+1.
- Writeback: for each port with wb_valid, occupied target and done=0, set done, value, aux, redirect. Writeback to unoccupied or already-done entry ignored. Two ports on same tag in same cycle: lowest port index wins.
- Retire, evaluated on head when occupied&&done:
  - ALU/load: commit_valid pulse, commit_value=value.
  - branch, redirect=0: retire, commit_dest forced 0.
  - branch, redirect=1: retire, flush_valid pulse, flush_pc={aux[XLEN-1:1],0}.
  - jalr: commit_value=pc+4, always flush to {aux[XLEN-1:1],0}.
  - store: store_valid held high with store_addr=value, store_data=aux until store_ready; retires on edge where store_ready=1, no commit_valid.
- Flush edge: all entries cleared, head=tail, count=0; allocation and writebacks on that edge discarded.
- Simultaneous alloc and retire: count unchanged, both occur; alloc succeeds when full only if count<DEPTH before edge (no same-edge bypass).
- rdy low: no alloc/writeback/retire; pulse outputs drop to 0, store_valid holds.

## Timing
- Alloc at edge N; earliest writeback edge N+1; earliest retire edge N+2; commit_valid/flush_valid high cycle after that edge, exactly one cycle.
- Throughput: one retire per cycle; back-to-back commits sustain.
- rd_done/rd_value see writebacks the cycle after the wb edge (no same-cycle bypass).
- store_valid combinational from head state; store_ready sampled only while store_valid.
- clr mid-store: store_valid drops immediately (async).

## Test plan
- Fill: 16 allocs with no wb -> count=16, alloc_ready=0, alloc_tag wraps 0..15; retire one -> alloc_ready=1.
- Out-of-order wb: alloc tags 0,1,2, wb 2 then 1 then 0 -> commits strictly tag 0,1,2 on consecutive cycles with correct values.
- Dual-port conflict: wb ports 0 and 1 both tag 3 (0xAA, 0xBB) same cycle -> commit_value=0xAA.
- Mispredict: tags 0 (branch, redirect, aux=0x1001),1,2 done -> flush_valid one cycle, flush_pc=0x1000, count=0, tags 1,2 never commit.
- Store stall: head store addr 0x20 data 0x5 done, store_ready low 3 cycles -> store_valid held, head unchanged; store_ready=1 -> retires, next entry commits next cycle.
- Async clr asserted mid-operation between edges -> all outputs 0 immediately, count=0.
